// File: rtl/cnn_check_pkg.sv
// cnn_check_pkg: shared types and helpers for the
// CNN output feature-map checker.
package cnn_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int M_DEF = 2;
    localparam int R_DEF = 4;
    localparam int C_DEF = 4;

    function automatic int total_elems(
        input int m,
        input int r,
        input int c
    );
        return m * r * c;
    endfunction

    // Index widths never collapse to zero for unit dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int M_IDX_W = idx_w(M_DEF);
    localparam int R_IDX_W = idx_w(R_DEF);
    localparam int C_IDX_W = idx_w(C_DEF);

endpackage

// File: rtl/cnn_tol_compare.sv
// cnn_tol_compare: one registered abs-diff vs tolerance
// compare stage; carries index and both values through.
module cnn_tol_compare
    import cnn_check_pkg::*;
#(
    parameter int WIDTH_p     = 16,
    parameter int TOL_SHIFT_p = 7,
    parameter int ABS_TOL_p   = 1,
    parameter int MW_p        = M_IDX_W,
    parameter int RW_p        = R_IDX_W,
    parameter int CW_p        = C_IDX_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic               last_i,
    input  logic [MW_p-1:0]    m_i,
    input  logic [RW_p-1:0]    r_i,
    input  logic [CW_p-1:0]    c_i,
    input  logic [WIDTH_p-1:0] dut_i,
    input  logic [WIDTH_p-1:0] gold_i,
    output logic               valid_o,
    output logic               last_o,
    output logic               mismatch_o,
    output logic [MW_p-1:0]    m_o,
    output logic [RW_p-1:0]    r_o,
    output logic [CW_p-1:0]    c_o,
    output logic [WIDTH_p-1:0] dut_o,
    output logic [WIDTH_p-1:0] gold_o
);

    localparam int DW = WIDTH_p + 1;

    logic signed [DW-1:0] diff;
    logic [DW-1:0]        abs_diff;
    logic [DW-1:0]        tol;
    logic [WIDTH_p-1:0]   abs_gold;
    logic                 miss;

    // One extra bit keeps -2^(W-1) and full-range diffs exact.
    always_comb begin
        diff = {dut_i[WIDTH_p-1], dut_i}
             - {gold_i[WIDTH_p-1], gold_i};
        abs_diff = diff[DW-1] ? DW'(-diff) : DW'(diff);
        abs_gold = gold_i[WIDTH_p-1] ? (~gold_i + 1'b1)
                                     : gold_i;
        tol = ({1'b0, abs_gold} >> TOL_SHIFT_p)
            + DW'(ABS_TOL_p);
        miss = abs_diff > tol;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            mismatch_o <= 1'b0;
            m_o        <= '0;
            r_o        <= '0;
            c_o        <= '0;
            dut_o      <= '0;
            gold_o     <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                last_o     <= last_i;
                mismatch_o <= miss;
                m_o        <= m_i;
                r_o        <= r_i;
                c_o        <= c_i;
                dut_o      <= dut_i;
                gold_o     <= gold_i;
            end
        end
    end

endmodule

// File: rtl/cnn_fm_checker.sv
// cnn_fm_checker: streams DUT/golden pairs in m-r-c order
// and reports pass, mismatch count and first mismatch.
module cnn_fm_checker
    import cnn_check_pkg::*;
#(
    parameter int M_p         = M_DEF,
    parameter int R_p         = R_DEF,
    parameter int C_p         = C_DEF,
    parameter int WIDTH_p     = 16,
    parameter int TOL_SHIFT_p = 7,
    parameter int ABS_TOL_p   = 1,
    localparam int MW = idx_w(M_p),
    localparam int RW = idx_w(R_p),
    localparam int CW = idx_w(C_p),
    localparam int EW =
        $clog2(total_elems(M_p, R_p, C_p) + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               dut_valid_i,
    input  logic [WIDTH_p-1:0] dut_data_i,
    input  logic               gold_valid_i,
    input  logic [WIDTH_p-1:0] gold_data_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [EW-1:0]      err_count_o,
    output logic               first_err_valid_o,
    output logic [MW-1:0]      first_err_m_o,
    output logic [RW-1:0]      first_err_r_o,
    output logic [CW-1:0]      first_err_c_o,
    output logic [WIDTH_p-1:0] first_err_dut_o,
    output logic [WIDTH_p-1:0] first_err_gold_o
);

    localparam logic [MW-1:0] M_LAST = MW'(M_p - 1);
    localparam logic [RW-1:0] R_LAST = RW'(R_p - 1);
    localparam logic [CW-1:0] C_LAST = CW'(C_p - 1);

    state_t state_q, state_d;

    logic [MW-1:0] m_q;
    logic [RW-1:0] r_q;
    logic [CW-1:0] c_q;
    logic          accept, at_last, start_ok;

    logic               cmp_valid, cmp_last, cmp_miss;
    logic [MW-1:0]      cmp_m;
    logic [RW-1:0]      cmp_r;
    logic [CW-1:0]      cmp_c;
    logic [WIDTH_p-1:0] cmp_dut, cmp_gold;

    assign at_last  = (m_q == M_LAST) && (r_q == R_LAST)
                   && (c_q == C_LAST);
    assign accept   = ready_o & dut_valid_i & gold_valid_i;
    assign start_ok = start_i
                   & ((state_q == IDLE) | (state_q == DONE));

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (cmp_valid && cmp_last) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (start_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Last pair sits in the compare stage: stop accepting.
    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            RUN: begin
                ready_o = ~(cmp_valid & cmp_last);
                busy_o  = 1'b1;
            end
            DRAIN:   busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign pass_o = done_o & (err_count_o == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i || start_ok) begin
            m_q <= '0;
            r_q <= '0;
            c_q <= '0;
        end else if (accept && !at_last) begin
            if (c_q == C_LAST) begin
                c_q <= '0;
                if (r_q == R_LAST) begin
                    r_q <= '0;
                    m_q <= m_q + 1'b1;
                end else begin
                    r_q <= r_q + 1'b1;
                end
            end else begin
                c_q <= c_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || start_ok) begin
            err_count_o       <= '0;
            first_err_valid_o <= 1'b0;
            first_err_m_o     <= '0;
            first_err_r_o     <= '0;
            first_err_c_o     <= '0;
            first_err_dut_o   <= '0;
            first_err_gold_o  <= '0;
        end else if (cmp_valid && cmp_miss) begin
            err_count_o <= err_count_o + 1'b1;
            if (!first_err_valid_o) begin
                first_err_valid_o <= 1'b1;
                first_err_m_o     <= cmp_m;
                first_err_r_o     <= cmp_r;
                first_err_c_o     <= cmp_c;
                first_err_dut_o   <= cmp_dut;
                first_err_gold_o  <= cmp_gold;
            end
        end
    end

    cnn_tol_compare #(
        .WIDTH_p     (WIDTH_p),
        .TOL_SHIFT_p (TOL_SHIFT_p),
        .ABS_TOL_p   (ABS_TOL_p),
        .MW_p        (MW),
        .RW_p        (RW),
        .CW_p        (CW)
    ) u_cmp (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .valid_i    (accept),
        .last_i     (at_last),
        .m_i        (m_q),
        .r_i        (r_q),
        .c_i        (c_q),
        .dut_i      (dut_data_i),
        .gold_i     (gold_data_i),
        .valid_o    (cmp_valid),
        .last_o     (cmp_last),
        .mismatch_o (cmp_miss),
        .m_o        (cmp_m),
        .r_o        (cmp_r),
        .c_o        (cmp_c),
        .dut_o      (cmp_dut),
        .gold_o     (cmp_gold)
    );

endmodule

// File: tb/tb_cnn_fm_checker.sv
// tb_cnn_fm_checker: directed runs with a result scoreboard
// popped by a monitor whenever done_o rises.
module tb_cnn_fm_checker;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        reset_i, start_i;
    logic        dut_valid_i, gold_valid_i;
    logic [15:0] dut_data_i, gold_data_i;
    logic        ready_o, busy_o, done_o, pass_o;
    logic [5:0]  err_count_o;
    logic        first_err_valid_o;
    logic        first_err_m_o;
    logic [1:0]  first_err_r_o, first_err_c_o;
    logic [15:0] first_err_dut_o, first_err_gold_o;

    cnn_fm_checker dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .start_i           (start_i),
        .dut_valid_i       (dut_valid_i),
        .dut_data_i        (dut_data_i),
        .gold_valid_i      (gold_valid_i),
        .gold_data_i       (gold_data_i),
        .ready_o           (ready_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .pass_o            (pass_o),
        .err_count_o       (err_count_o),
        .first_err_valid_o (first_err_valid_o),
        .first_err_m_o     (first_err_m_o),
        .first_err_r_o     (first_err_r_o),
        .first_err_c_o     (first_err_c_o),
        .first_err_dut_o   (first_err_dut_o),
        .first_err_gold_o  (first_err_gold_o)
    );

    typedef struct {
        bit          pass;
        int          errs;
        bit          fev;
        int          fm, fr, fc;
        logic [15:0] fd, fg;
        int          nacc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] dv[32];
    logic [15:0] gv[32];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          last_acc = 0;
    logic        done_d = 1'b0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Monitor: counts handshakes, scores each finished run.
    always @(negedge clk_i) begin
        exp_t e;
        cyc++;
        if (reset_i) begin
            acc_cnt = 0;
        end else if (ready_o && dut_valid_i
                     && gold_valid_i) begin
            acc_cnt++;
            last_acc = cyc;
        end
        if (done_o && !done_d) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pass", pass_o, e.pass);
                chk("err_count", err_count_o, e.errs);
                chk("first_valid", first_err_valid_o, e.fev);
                chk("first_m", first_err_m_o, e.fm);
                chk("first_r", first_err_r_o, e.fr);
                chk("first_c", first_err_c_o, e.fc);
                chk("first_dut", first_err_dut_o, e.fd);
                chk("first_gold", first_err_gold_o, e.fg);
                chk("accepts", acc_cnt, e.nacc);
                chk("done_latency", cyc - last_acc, 3);
                acc_cnt = 0;
            end
        end
        done_d = done_o;
    end

    task automatic push_exp(input bit pass, input int errs,
                            input bit fev, input int fm,
                            input int fr, input int fc,
                            input logic [15:0] fd,
                            input logic [15:0] fg);
        exp_t e;
        e.pass = pass;
        e.errs = errs;
        e.fev  = fev;
        e.fm   = fm;
        e.fr   = fr;
        e.fc   = fc;
        e.fd   = fd;
        e.fg   = fg;
        e.nacc = 32;
        exp_q.push_back(e);
    endtask

    task automatic start_pulse();
        @(posedge clk_i);
        #1 start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic feed(input int lo, input int hi,
                        input bit tgl);
        int k = lo;
        int n = 0;
        bit g = 1'b0;
        while (k < hi && n < 500) begin
            @(posedge clk_i);
            #1;
            g = tgl ? ~g : 1'b1;
            dut_valid_i  = 1'b1;
            gold_valid_i = g;
            dut_data_i   = dv[k];
            gold_data_i  = gv[k];
            if (ready_o && g) k++;
            n++;
        end
        @(posedge clk_i);
        #1;
        dut_valid_i  = 1'b0;
        gold_valid_i = 1'b0;
        chk("feed_progress", k, hi);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("done_timeout", done_o, 1);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 32; k++) begin
            dv[k] = 16'(k * 8);
            gv[k] = 16'(k * 8);
        end
    endtask

    task automatic fill_const(input logic [15:0] d,
                              input logic [15:0] g);
        for (int k = 0; k < 32; k++) begin
            dv[k] = d;
            gv[k] = g;
        end
    endtask

    task automatic run(input bit tgl);
        start_pulse();
        feed(0, 32, tgl);
        wait_done();
    endtask

    initial begin
        reset_i      = 1'b1;
        start_i      = 1'b0;
        dut_valid_i  = 1'b0;
        gold_valid_i = 1'b0;
        dut_data_i   = '0;
        gold_data_i  = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_pass", pass_o, 0);
        chk("rst_err", err_count_o, 0);
        chk("rst_fev", first_err_valid_o, 0);
        chk("rst_fdut", first_err_dut_o, 0);

        fill_ramp();
        push_exp(1, 0, 0, 0, 0, 0, 0, 0);
        run(0);

        fill_const(16'd1008, 16'd1000);
        push_exp(1, 0, 0, 0, 0, 0, 0, 0);
        run(0);

        dv[27] = 16'd1009;
        push_exp(0, 1, 1, 1, 2, 3, 16'd1009, 16'd1000);
        run(0);

        fill_ramp();
        dv[5]  = 16'd140;
        dv[20] = 16'd210;
        push_exp(0, 2, 1, 0, 1, 1, 16'd140, 16'd40);
        run(0);

        fill_ramp();
        push_exp(1, 0, 0, 0, 0, 0, 0, 0);
        run(1);

        fill_const(16'h8100, 16'h8000);
        push_exp(1, 0, 0, 0, 0, 0, 0, 0);
        run(0);

        dv[31] = 16'h8102;
        push_exp(0, 1, 1, 1, 3, 3, 16'h8102, 16'h8000);
        run(0);

        fill_ramp();
        dv[3] = 16'd124;
        start_pulse();
        feed(0, 10, 0);
        @(negedge clk_i);
        chk("mid_err", err_count_o, 1);
        chk("mid_busy", busy_o, 1);
        @(posedge clk_i);
        #1 reset_i = 1'b1;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("rr_busy", busy_o, 0);
        chk("rr_ready", ready_o, 0);
        chk("rr_done", done_o, 0);
        chk("rr_err", err_count_o, 0);
        chk("rr_fev", first_err_valid_o, 0);

        fill_ramp();
        dv[2] = 16'd116;
        push_exp(0, 1, 1, 0, 0, 2, 16'd116, 16'd16);
        start_pulse();
        feed(0, 5, 0);
        start_pulse();
        feed(5, 32, 0);
        wait_done();

        @(posedge clk_i);
        #1 start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        chk("rs_done", done_o, 0);
        chk("rs_busy", busy_o, 1);
        chk("rs_err", err_count_o, 0);
        chk("rs_fev", first_err_valid_o, 0);
        chk("rs_pass", pass_o, 0);
        fill_ramp();
        push_exp(1, 0, 0, 0, 0, 0, 0, 0);
        feed(0, 32, 0);
        wait_done();

        repeat (3) @(negedge clk_i);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
